// File: rtl/victim_writeback_buffer.sv
// victim_writeback_buffer
//   Queues dirty 256-bit lines evicted by the victim cache and drains each one
//   to main memory as eight 32-bit write beats. A combinational snoop port lets
//   a processor read see the youngest buffered copy of its line.
//
//   Build option: WB_COALESCE_EN -- when defined, a push whose block address
//   matches a queued entry (other than the head being drained) overwrites that
//   entry in place instead of allocating a new one.
//
// Ports
//   clk_i, rst_i            clock, asynchronous active-high reset
//   wb_valid_i/wb_addr_i/   evicted line offered by the victim cache
//   wb_line_i/wb_ready_o    (push on wb_valid_i & wb_ready_o)
//   mem_valid_o/mem_addr_o/ write beat to memory (23-bit word address),
//   mem_wdata_o/mem_ack_i   advanced on mem_ack_i
//   lookup_addr_i/          snoop of a processor read against buffered lines
//   lookup_hit_o/lookup_data_o
//   count_o, empty_o        occupancy
//
// Drain FSM
//   state   | meaning
//   S_IDLE  | nothing presented to memory
//   S_DRAIN | beat beat_q of the head line presented, waiting for mem_ack_i

module victim_writeback_buffer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               wb_valid_i,
  input  logic [19:0]        wb_addr_i,
  input  logic [255:0]       wb_line_i,
  output logic               wb_ready_o,
  output logic               mem_valid_o,
  output logic [22:0]        mem_addr_o,
  output logic [31:0]        mem_wdata_o,
  input  logic               mem_ack_i,
  input  logic [22:0]        lookup_addr_i,
  output logic               lookup_hit_o,
  output logic [31:0]        lookup_data_o,
  output logic [CNT_W-1:0]   count_o,
  output logic               empty_o
);

  localparam int PTR_W = CNT_W - 1;

  typedef enum logic {S_IDLE, S_DRAIN} state_t;

  logic [DEPTH-1:0]  valid_q;
  logic [19:0]       addr_q [DEPTH];
  logic [255:0]      line_q [DEPTH];
  logic [PTR_W-1:0]  head_q, tail_q;
  logic [CNT_W-1:0]  count_q, count_d;
  state_t            state_q;
  logic [2:0]        beat_q;
  logic              mem_valid_q;
  logic [22:0]       mem_addr_q;
  logic [31:0]       mem_wdata_q;

  logic              push, pop, alloc, coal_hit;
  logic [PTR_W-1:0]  coal_idx, wr_idx, head_nxt;
  logic [PTR_W-1:0]  load_idx, snoop_idx;
  logic [2:0]        load_beat;
  logic [19:0]       load_addr;
  logic [255:0]      load_line;
  logic [31:0]       load_word;

  assign wb_ready_o = (count_q != CNT_W'(DEPTH));
  assign push       = wb_valid_i & wb_ready_o;
  assign pop        = (state_q == S_DRAIN) & mem_ack_i & (beat_q == 3'd7);
  assign head_nxt   = head_q + PTR_W'(1);

  // At most one non-head entry can share an address: duplicates only arise
  // when a push matches the draining head.
  always_comb begin
    coal_hit = 1'b0;
    coal_idx = '0;
`ifdef WB_COALESCE_EN
    for (int k = 0; k < DEPTH; k++) begin
      if (valid_q[k] && addr_q[k] == wb_addr_i &&
          !(state_q == S_DRAIN && PTR_W'(k) == head_q)) begin
        coal_hit = 1'b1;
        coal_idx = PTR_W'(k);
      end
    end
`endif
  end

  assign alloc  = push & ~coal_hit;
  assign wr_idx = coal_hit ? coal_idx : tail_q;

  always_comb begin
    count_d = count_q;
    if (alloc && !pop)
      count_d = count_q + CNT_W'(1);
    else if (!alloc && pop)
      count_d = count_q - CNT_W'(1);
  end

  // Beat to be registered onto the memory port at this edge. The entry being
  // written this cycle is forwarded so a same-edge push/overwrite is not missed.
  always_comb begin
    load_idx  = head_q;
    load_beat = 3'd0;
    if (state_q == S_DRAIN) begin
      if (beat_q == 3'd7)
        load_idx = head_nxt;
      else
        load_beat = beat_q + 3'd1;
    end
    load_addr = (push && wr_idx == load_idx) ? wb_addr_i : addr_q[load_idx];
    load_line = (push && wr_idx == load_idx) ? wb_line_i : line_q[load_idx];
    load_word = load_line[{load_beat, 5'd0} +: 32];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_nxt;
      end
      if (alloc) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + PTR_W'(1);
      end
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      addr_q[wr_idx] <= wb_addr_i;
      line_q[wr_idx] <= wb_line_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      beat_q      <= 3'd0;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (count_q != '0) begin
            state_q     <= S_DRAIN;
            beat_q      <= 3'd0;
            mem_valid_q <= 1'b1;
            mem_addr_q  <= {load_addr, load_beat};
            mem_wdata_q <= load_word;
          end
        end
        S_DRAIN: begin
          if (mem_ack_i) begin
            if (beat_q == 3'd7 && count_d == '0) begin
              state_q     <= S_IDLE;
              beat_q      <= 3'd0;
              mem_valid_q <= 1'b0;
            end else begin
              beat_q      <= load_beat;
              mem_addr_q  <= {load_addr, load_beat};
              mem_wdata_q <= load_word;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Scan oldest to youngest so the last match is the youngest copy.
  always_comb begin
    lookup_hit_o  = 1'b0;
    lookup_data_o = '0;
    snoop_idx     = head_q;
    for (int k = 0; k < DEPTH; k++) begin
      snoop_idx = head_q + PTR_W'(k);
      if (valid_q[snoop_idx] && addr_q[snoop_idx] == lookup_addr_i[22:3]) begin
        lookup_hit_o  = 1'b1;
        lookup_data_o = line_q[snoop_idx][{lookup_addr_i[2:0], 5'd0} +: 32];
      end
    end
  end

  assign mem_valid_o = mem_valid_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign count_o     = count_q;
  assign empty_o     = (count_q == '0);

endmodule

// File: tb/tb_victim_writeback_buffer.sv
module tb_victim_writeback_buffer;

  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              wb_valid;
  logic [19:0]       wb_addr;
  logic [255:0]      wb_line;
  logic              wb_ready;
  logic              mem_valid;
  logic [22:0]       mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ack;
  logic [22:0]       lookup_addr;
  logic              lookup_hit;
  logic [31:0]       lookup_data;
  logic [CNT_W-1:0]  count;
  logic              empty;

  int n_asrt = 0;
  int n_fail = 0;

  victim_writeback_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst),
    .wb_valid_i(wb_valid), .wb_addr_i(wb_addr), .wb_line_i(wb_line),
    .wb_ready_o(wb_ready),
    .mem_valid_o(mem_valid), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_ack_i(mem_ack),
    .lookup_addr_i(lookup_addr), .lookup_hit_o(lookup_hit), .lookup_data_o(lookup_data),
    .count_o(count), .empty_o(empty)
  );

  always #5 clk = ~clk;

  // Reference model: queue of lines in arrival order, front is being drained.
  typedef struct packed {
    logic [19:0]  addr;
    logic [255:0] line;
  } ent_t;

  ent_t q[$];
  bit   m_busy;
  int   m_beat;

  function automatic logic [31:0] word_of(input logic [255:0] l, input int k);
    return l[k*32 +: 32];
  endfunction

  function automatic logic [255:0] rand_line();
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_busy = 1'b0;
    m_beat = 0;
  endtask

  task automatic model_step();
    bit   do_push, do_pop, was_busy;
    int   cidx, pre_size;
    ent_t e;
    do_push  = wb_valid && (q.size() < DEPTH);
    do_pop   = m_busy && mem_ack && (m_beat == 7);
    was_busy = m_busy;
    pre_size = q.size();
    cidx     = -1;
`ifdef WB_COALESCE_EN
    if (do_push)
      for (int j = 0; j < q.size(); j++)
        if (q[j].addr == wb_addr && !(m_busy && j == 0)) cidx = j;
`endif
    if (do_pop) void'(q.pop_front());
    if (do_push) begin
      if (cidx >= 0) begin
        if (do_pop) cidx = cidx - 1;
        e = q[cidx];
        e.line = wb_line;
        q[cidx] = e;
      end else begin
        e.addr = wb_addr;
        e.line = wb_line;
        q.push_back(e);
      end
    end
    if (was_busy) begin
      if (mem_ack) begin
        if (m_beat == 7) begin
          m_beat = 0;
          m_busy = (q.size() != 0);
        end else begin
          m_beat = m_beat + 1;
        end
      end
    end else if (pre_size != 0) begin
      m_busy = 1'b1;
      m_beat = 0;
    end
  endtask

  task automatic check_all();
    logic        exp_hit;
    logic [31:0] exp_data;
    chk("count", 32'(count), 32'(q.size()));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("wb_ready", 32'(wb_ready), 32'(q.size() != DEPTH));
    chk("mem_valid", 32'(mem_valid), 32'(m_busy));
    if (m_busy) begin
      chk("mem_addr", 32'(mem_addr), 32'({q[0].addr, 3'(m_beat)}));
      chk("mem_wdata", mem_wdata, word_of(q[0].line, m_beat));
    end
    exp_hit  = 1'b0;
    exp_data = '0;
    for (int j = 0; j < q.size(); j++)
      if (q[j].addr == lookup_addr[22:3]) begin
        exp_hit  = 1'b1;
        exp_data = word_of(q[j].line, int'(lookup_addr[2:0]));
      end
    chk("lookup_hit", 32'(lookup_hit), 32'(exp_hit));
    chk("lookup_data", lookup_data, exp_data);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic set_push(input logic [19:0] a, input logic [255:0] l);
    wb_valid = 1'b1;
    wb_addr  = a;
    wb_line  = l;
  endtask

  task automatic drain_all();
    int n;
    wb_valid = 1'b0;
    mem_ack  = 1'b1;
    n = 0;
    while ((q.size() != 0 || m_busy) && n < 100) begin
      tick();
      n++;
    end
    chk("drain_timeout", 32'(n >= 100), 32'(0));
  endtask

  initial begin
    logic [255:0] l1, l2;
    int cyc;

    rst = 1'b1; wb_valid = 1'b0; wb_addr = '0; wb_line = '0;
    mem_ack = 1'b0; lookup_addr = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    chk("rst_mem_addr", 32'(mem_addr), 32'(0));
    chk("rst_mem_wdata", mem_wdata, 32'(0));
    rst = 1'b0;

    // 1: single line, ack tied high
    for (int k = 0; k < 8; k++) l1[k*32 +: 32] = 32'h1000_0000 + k;
    set_push(20'h00012, l1);
    mem_ack = 1'b1;
    lookup_addr = 23'h000095;
    tick();
    wb_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("t1_addr", 32'(mem_addr), 32'h90 + k);
      chk("t1_data", mem_wdata, 32'h1000_0000 + k);
    end
    tick();
    chk("t1_count", 32'(count), 0);
    chk("t1_empty", 32'(empty), 1);

    // 2: fill with ack low, overflow attempt, then release one line
    mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_push(20'(32'h100 + i), rand_line());
      tick();
    end
    chk("t2_count_full", 32'(count), 4);
    chk("t2_ready_full", 32'(wb_ready), 0);
    set_push(20'h001ff, rand_line());
    tick();
    chk("t2_count_ignored", 32'(count), 4);
    wb_valid = 1'b0;
    mem_ack  = 1'b1;
    repeat (8) tick();
    chk("t2_count_after", 32'(count), 3);
    chk("t2_ready_after", 32'(wb_ready), 1);
    drain_all();

    // 3: duplicate address, youngest wins / coalesce
    mem_ack = 1'b0;
    l1 = rand_line();
    l2 = rand_line();
    set_push(20'h00040, l1);
    tick();
    set_push(20'h00040, l2);
    tick();
    wb_valid = 1'b0;
    lookup_addr = 23'h000203;
    #1;
    chk("t3_hit", 32'(lookup_hit), 1);
    chk("t3_data", lookup_data, word_of(l2, 3));
`ifdef WB_COALESCE_EN
    chk("t3_count", 32'(count), 1);
`else
    chk("t3_count", 32'(count), 2);
`endif
    drain_all();

    // 4: ack every other cycle
    mem_ack = 1'b0;
    set_push(20'h00077, rand_line());
    tick();
    wb_valid = 1'b0;
    tick();
    cyc = 0;
    while (mem_valid && cyc < 40) begin
      mem_ack = (cyc % 2 == 1);
      tick();
      cyc++;
    end
    chk("t4_cycles", 32'(cyc), 16);

    // 5: reset in the middle of a two-line drain
    mem_ack = 1'b1;
    set_push(20'h000a0, rand_line());
    tick();
    set_push(20'h000b0, rand_line());
    tick();
    wb_valid = 1'b0;
    lookup_addr = {20'h000a0, 3'd1};
    cyc = 0;
    while (!(m_busy && m_beat == 4) && cyc < 20) begin
      tick();
      cyc++;
    end
    chk("t5_wait", 32'(cyc >= 20), 0);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("t5_mem_valid", 32'(mem_valid), 0);
    chk("t5_count", 32'(count), 0);
    chk("t5_empty", 32'(empty), 1);
    chk("t5_hit", 32'(lookup_hit), 0);
    check_all();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t5_quiet", 32'(mem_valid), 0);
    end

    // 6: push and pop in the same cycle at count 2
    mem_ack = 1'b0;
    set_push(20'h000c0, rand_line());
    tick();
    set_push(20'h000d0, rand_line());
    tick();
    wb_valid = 1'b0;
    mem_ack  = 1'b1;
    cyc = 0;
    while (!(m_busy && m_beat == 7) && cyc < 20) begin
      tick();
      cyc++;
    end
    chk("t6_wait", 32'(cyc >= 20), 0);
    set_push(20'h000e0, rand_line());
    tick();
    wb_valid = 1'b0;
    chk("t6_count", 32'(count), 2);
    chk("t6_next_addr", 32'(mem_addr), 32'({20'h000d0, 3'd0}));
    drain_all();

    // Random traffic with address collisions
    for (int i = 0; i < 800; i++) begin
      wb_valid    = ($urandom % 2) == 1;
      wb_addr     = 20'(32'h300 + $urandom_range(0, 5));
      wb_line     = rand_line();
      mem_ack     = ($urandom % 4) != 0;
      lookup_addr = {20'(32'h300 + $urandom_range(0, 5)), 3'($urandom)};
      tick();
    end
    drain_all();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule

// File: doc/victim_writeback_buffer.md
Name: victim_writeback_buffer

Overview:
- Sits directly downstream of the victim cache. It accepts the dirty 256-bit lines the victim cache displaces, queues them, and drains each one to main memory as eight 32-bit write beats.
- It provides a combinational snoop port so that a processor read going to memory never returns data older than a line still held in the buffer.
- All addresses are 23-bit word addresses. A block address is addr[22:3]; the word within the line is addr[2:0].

Parameters:
DEPTH, 4, number of line entries; must be a power of two, 2..8
CNT_W, 3, width of occupancy count; must equal log2(DEPTH)+1

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
wb_valid  in  1  victim cache presents an evicted dirty line
wb_addr  in  20  block address of the evicted line
wb_line  in  256  line data; word k is bits [32k+31:32k]
wb_ready  out  1  buffer can accept a line (not full)
mem_valid  out  1  write beat presented to memory
mem_addr  out  23  word address of the current beat
mem_wdata  out  32  data of the current beat
mem_ack  in  1  memory accepts the current beat
lookup_addr  in  23  word address of a processor read heading to memory
lookup_hit  out  1  a buffered line matches lookup_addr[22:3]
lookup_data  out  32  the matching word; 0 when there is no hit
count  out  CNT_W  number of occupied entries
empty  out  1  count == 0

Behaviour:
- Storage is a circular FIFO: per entry a valid bit, a 20-bit block address and a 256-bit line, with head and tail pointers wrapping modulo DEPTH.
- Reset, asynchronous and applied immediately:
  - all valid bits = 0, head = tail = 0, count = 0, empty = 1;
  - FSM returns to IDLE and the beat counter = 0;
  - mem_valid = 0, mem_addr = 0, mem_wdata = 0, wb_ready = 1, lookup_hit = 0.
  - Lines in flight are discarded, including a partly drained line.
- Push:
  - A push occurs on a clock edge where wb_valid & wb_ready. The line is written at tail, tail advances, count increments.
  - wb_ready = (count != DEPTH) and is computed from registered count only. When full, a push is refused even if a pop happens in the same cycle.
  - wb_valid while wb_ready = 0 has no effect. The victim cache must hold its line until wb_ready goes high.
- Drain FSM:
  - IDLE: mem_valid = 0. If count != 0 on a clock edge, go to DRAIN with beat = 0.
  - DRAIN: mem_valid = 1, mem_addr = {addr[head], beat}, mem_wdata = word[beat] of line[head].
    - mem_ack = 0: all outputs are held stable.
    - mem_ack = 1 and beat < 7: beat increments.
    - mem_ack = 1 and beat = 7: pop head (valid = 0, head advances, count decrements). Then go to DRAIN with beat = 0 if the post-pop count != 0, else go to IDLE.
  - Latency: a line pushed into an empty buffer at edge N has its first beat presented after edge N+1. With mem_ack tied high, one line drains in 8 cycles, and back-to-back lines drain with no bubble.
- Simultaneous push and pop in one cycle: count is unchanged and both pointers advance.
- Snoop:
  - Purely combinational. It compares lookup_addr[22:3] against every valid entry, including the head while it is draining, until its final beat is acked.
  - If several entries match, the youngest (closest to tail) wins.
  - lookup_data is word lookup_addr[2:0] of the winning line.
  - A line being pushed in the current cycle is not visible to the snoop until after the edge.
- All registered state updates on the rising edge of clk only.

Optional Feature:
WB_COALESCE_EN
- Defined: on a push whose wb_addr matches a valid entry that is not the head currently in DRAIN, the matching entry's line is overwritten in place. Tail and count are unchanged. The push is still gated by wb_ready.
- A match against the draining head always allocates a new entry.
- Not defined: every push allocates a new entry, and duplicate addresses coexist, resolved by the youngest-wins rule.

Test Plan:
1. Reset, then push addr 20'h00012 with line words 0..7 = 32'h1000_0000+k, mem_ack = 1 → from the cycle after the push, 8 consecutive beats: mem_addr 23'h000090..23'h000097 with matching data; count returns to 0 and empty = 1.
2. Fill DEPTH = 4 with mem_ack = 0 → wb_ready = 0 and count = 4; a fifth wb_valid is ignored; raise mem_ack → after 8 acks count = 3 and wb_ready = 1.
3. Push 20'h00040 twice with different data, coalescing off, lookup_addr 23'h000203 → lookup_hit = 1 and lookup_data is word 3 of the second line; with WB_COALESCE_EN, count = 1.
4. Toggle mem_ack high every other cycle → each beat's addr/data stays stable until acked; the line completes in 16 cycles.
5. Assert rst after the 4th beat of a 2-entry drain → mem_valid = 0 immediately, count = 0, empty = 1, lookup_hit = 0; after reset is released, no beats appear until a new push.
6. Push and pop in the same cycle at count = 2 → count stays 2, and the next drained address is the second-oldest line.
